// File: rtl/bg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bg_pkg
// Description : Shared definitions for the background layer engine. Holds the
//               line sequencer state encoding, the default parameter values
//               and a counter-width helper.
// Config      : none (the optional BGCTL_LAYER_ENABLE_EN macro is consumed by
//               bg_layer_engine only)
// Revision    : 1.0 - initial release
// ============================================================================
package bg_pkg;

    localparam int c_DEF_NUM_LAYERS     = 4;
    localparam int c_DEF_TILES_PER_LINE = 4;
    localparam int c_DEF_ADDR_W         = 4;
    localparam int c_DEF_DATA_W         = 4;
    localparam int c_DEF_PAN_W          = 4;
    localparam int c_DEF_PIX_W          = 4;

    // Colour index is one bit from each of the two bit planes.
    localparam int c_IDX_W = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHAR = 3'd1,
        TILE = 3'd2,
        CAPT = 3'd3,
        EMIT = 3'd4,
        DONE = 3'd5
    } bgState_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : bg_pkg
`default_nettype wire

// File: rtl/bg_pixel_mux.sv
`default_nettype none
// ============================================================================
// Module      : bg_pixel_mux
// Description : Combinational priority compositor. Colour index 0 is
//               transparent; the lowest-numbered layer with a non-zero index
//               wins and its palette offset is added to that index (wrapping
//               at PIX_W bits). No opaque layer gives pixel 0.
// Ports       : layerIdx    in  NUM_LAYERS*2      packed colour indices
//               layerOffset in  NUM_LAYERS*PIX_W  packed palette offsets
//               pixelOut    out PIX_W             composited pixel
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module bg_pixel_mux
    import bg_pkg::*;
#(
    parameter int NUM_LAYERS = c_DEF_NUM_LAYERS,
    parameter int PIX_W      = c_DEF_PIX_W
) (
    input  logic [NUM_LAYERS*c_IDX_W-1:0] layerIdx,
    input  logic [NUM_LAYERS*PIX_W-1:0]   layerOffset,
    output logic [PIX_W-1:0]              pixelOut
);

    // Walk from the lowest priority layer up so the highest priority opaque
    // layer is the last one to overwrite the result.
    always_comb begin
        pixelOut = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layerIdx[i*c_IDX_W +: c_IDX_W] != '0) begin
                pixelOut = layerOffset[i*PIX_W +: PIX_W]
                         + PIX_W'(layerIdx[i*c_IDX_W +: c_IDX_W]);
            end
        end
    end

endmodule : bg_pixel_mux
`default_nettype wire

// File: rtl/bg_layer_engine.sv
`default_nettype none
// ============================================================================
// Module      : bg_layer_engine
// Description : Tile-based background line engine. For every tile column it
//               fetches, per layer, the character code, then the two bit
//               planes and palette offset addressed by that code, and then
//               emits DATA_W composited pixels MSB first. A line ends with a
//               one-cycle lineDone pulse.
// Ports       : clk             in  1                  clock
//               resetN          in  1                  async active-low reset
//               lineStarting    in  1                  start / restart line
//               layerPan        in  NUM_LAYERS*PAN_W   per-layer coarse pan
//               layerEnable     in  NUM_LAYERS         per-layer enable
//                                                      (BGCTL_LAYER_ENABLE_EN)
//               charAddrOut     out ADDR_W             character memory addr
//               palAddrOut      out ADDR_W             palette memory addr
//               tileLowAddrOut  out ADDR_W             low plane memory addr
//               tileHighAddrOut out ADDR_W             high plane memory addr
//               charDataIn      in  DATA_W             character read data
//               palDataIn       in  DATA_W             palette read data
//               tileLowDataIn   in  DATA_W             low plane read data
//               tileHighDataIn  in  DATA_W             high plane read data
//               pixelOut        out PIX_W              composited pixel
//               pixelValid      out 1                  pixelOut valid
//               lineDone        out 1                  end-of-line pulse
// Config      : BGCTL_LAYER_ENABLE_EN - adds layerEnable; a disabled layer
//               keeps its fetch slots but is forced transparent.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_layer_engine
    import bg_pkg::*;
#(
    parameter int NUM_LAYERS     = c_DEF_NUM_LAYERS,
    parameter int TILES_PER_LINE = c_DEF_TILES_PER_LINE,
    parameter int ADDR_W         = c_DEF_ADDR_W,
    parameter int DATA_W         = c_DEF_DATA_W,
    parameter int PAN_W          = c_DEF_PAN_W,
    parameter int PIX_W          = c_DEF_PIX_W
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        lineStarting,
    input  logic [NUM_LAYERS*PAN_W-1:0] layerPan,
`ifdef BGCTL_LAYER_ENABLE_EN
    input  logic [NUM_LAYERS-1:0]       layerEnable,
`endif
    output logic [ADDR_W-1:0]           charAddrOut,
    output logic [ADDR_W-1:0]           palAddrOut,
    output logic [ADDR_W-1:0]           tileLowAddrOut,
    output logic [ADDR_W-1:0]           tileHighAddrOut,
    input  logic [DATA_W-1:0]           charDataIn,
    input  logic [DATA_W-1:0]           palDataIn,
    input  logic [DATA_W-1:0]           tileLowDataIn,
    input  logic [DATA_W-1:0]           tileHighDataIn,
    output logic [PIX_W-1:0]            pixelOut,
    output logic                        pixelValid,
    output logic                        lineDone
);

    localparam int c_T_W = cntWidth(TILES_PER_LINE);
    localparam int c_L_W = cntWidth(NUM_LAYERS);
    localparam int c_P_W = cntWidth(DATA_W);

    localparam logic [c_T_W-1:0] c_LAST_TILE  = c_T_W'(TILES_PER_LINE - 1);
    localparam logic [c_L_W-1:0] c_LAST_LAYER = c_L_W'(NUM_LAYERS - 1);
    localparam logic [c_P_W-1:0] c_LAST_PIX   = c_P_W'(DATA_W - 1);

    bgState_t           r_state;
    logic [c_T_W-1:0]   r_tile;
    logic [c_L_W-1:0]   r_layer;
    logic [c_P_W-1:0]   r_pix;

    // Address hold registers: the outputs show the live address in the state
    // that issues it and the last issued value at all other times.
    logic [ADDR_W-1:0]  r_charAddrHold;
    logic [ADDR_W-1:0]  r_tileAddrHold;

    logic [DATA_W-1:0]  r_low  [NUM_LAYERS];
    logic [DATA_W-1:0]  r_high [NUM_LAYERS];
    logic [PIX_W-1:0]   r_pal  [NUM_LAYERS];

    logic [PAN_W-1:0]                w_pan;
    logic [ADDR_W-1:0]               w_charAddr;
    logic [ADDR_W-1:0]               w_tileAddr;
    logic [c_P_W-1:0]                w_bitSel;
    logic [NUM_LAYERS-1:0]           w_layerEn;
    logic [NUM_LAYERS*c_IDX_W-1:0]   w_idx;
    logic [NUM_LAYERS*PIX_W-1:0]     w_offs;
    logic [PIX_W-1:0]                w_muxPixel;

`ifdef BGCTL_LAYER_ENABLE_EN
    assign w_layerEn = layerEnable;
`else
    assign w_layerEn = '1;
`endif

    assign w_pan      = layerPan[r_layer*PAN_W +: PAN_W];
    assign w_charAddr = ADDR_W'(r_tile) + ADDR_W'(w_pan);
    assign w_tileAddr = ADDR_W'(charDataIn);

    // Pixels leave MSB first.
    assign w_bitSel = c_LAST_PIX - r_pix;

    // The tile and palette addresses must be presented in the same cycle the
    // character code arrives, so they pass straight through during TILE;
    // the memories then return plane/palette data in CAPT.
    assign charAddrOut     = (r_state == CHAR) ? w_charAddr : r_charAddrHold;
    assign tileLowAddrOut  = (r_state == TILE) ? w_tileAddr : r_tileAddrHold;
    assign tileHighAddrOut = tileLowAddrOut;
    assign palAddrOut      = tileLowAddrOut;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            assign w_idx[gi*c_IDX_W +: c_IDX_W] = w_layerEn[gi]
                ? {r_high[gi][w_bitSel], r_low[gi][w_bitSel]}
                : '0;
            assign w_offs[gi*PIX_W +: PIX_W] = r_pal[gi];
        end
    endgenerate

    bg_pixel_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .PIX_W      (PIX_W)
    ) u_pixelMux (
        .layerIdx    (w_idx),
        .layerOffset (w_offs),
        .pixelOut    (w_muxPixel)
    );

    // Pixel/line outputs decode only registered state, so reset clears them
    // without waiting for a clock edge.
    assign pixelValid = (r_state == EMIT);
    assign pixelOut   = (r_state == EMIT) ? w_muxPixel : '0;
    assign lineDone   = (r_state == DONE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= IDLE;
            r_tile         <= '0;
            r_layer        <= '0;
            r_pix          <= '0;
            r_charAddrHold <= '0;
            r_tileAddrHold <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_low[i]  <= '0;
                r_high[i] <= '0;
                r_pal[i]  <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                CHAR: begin
                    r_charAddrHold <= w_charAddr;
                    r_state        <= TILE;
                end
                TILE: begin
                    r_tileAddrHold <= w_tileAddr;
                    r_state        <= CAPT;
                end
                CAPT: begin
                    r_low[r_layer]  <= tileLowDataIn;
                    r_high[r_layer] <= tileHighDataIn;
                    r_pal[r_layer]  <= PIX_W'(palDataIn);
                    if (r_layer != c_LAST_LAYER) begin
                        r_layer <= r_layer + 1'b1;
                        r_state <= CHAR;
                    end else begin
                        r_layer <= '0;
                        r_pix   <= '0;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (r_pix == c_LAST_PIX) begin
                        r_pix <= '0;
                        if (r_tile != c_LAST_TILE) begin
                            r_tile  <= r_tile + 1'b1;
                            r_state <= CHAR;
                        end else begin
                            r_state <= DONE;
                        end
                    end else begin
                        r_pix <= r_pix + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // A start request overrides whatever the sequencer was doing and
            // silently abandons any line in flight.
            if (lineStarting) begin
                r_state <= CHAR;
                r_tile  <= '0;
                r_layer <= '0;
                r_pix   <= '0;
            end
        end
    end

endmodule : bg_layer_engine
`default_nettype wire
